// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style PIC acknowledge sequencer.
// Command encodings are the OCW2 [7:5] field (R, SL, EOI).
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } pic_state_e;

    localparam logic [2:0] CMD_NS_EOI     = 3'b001;
    localparam logic [2:0] CMD_S_EOI      = 3'b011;
    localparam logic [2:0] CMD_ROT_NS_EOI = 3'b101;
    localparam logic [2:0] CMD_ROT_S_EOI  = 3'b111;
    localparam logic [2:0] CMD_SET_PRI    = 3'b110;
    localparam logic [2:0] CMD_AEOI_SET   = 3'b100;
    localparam logic [2:0] CMD_AEOI_CLR   = 3'b000;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Position of a level in the rotating order: 0 is highest (LP+1), 7 is LP.
    function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lp);
        return level - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_rot_priority.sv
// Combinational rotating find-first: returns the highest-priority set bit of
// i_vec when the order is LP+1, LP+2, ..., LP (modulo 8).
module pic_rot_priority (
    input  logic [7:0] i_vec,
    input  logic [2:0] i_lp,
    output logic       o_valid,
    output logic [2:0] o_level
);

    logic [2:0] w_idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_valid = 1'b0;
        o_level = 3'd0;
        w_idx   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_idx = i_lp + 3'd1 + 3'(k);
            if (i_vec[w_idx]) begin
                o_valid = 1'b1;
                o_level = w_idx;
            end
        end
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259A-style PIC control: IRR/ISR, INT generation, two-pulse INTA handshake,
// rotating priority and OCW2 EOI decode. Optional automatic EOI: PIC_AEOI_EN.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter logic [2:0] LP_RESET    = 3'd7,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] IR,
    input  logic [7:0] IMR,
    input  logic [4:0] VECTOR_BASE,
    input  logic [7:0] OCW2,
    input  logic       OCW2_WR,
    input  logic       INTA_N,
    output logic       INT,
    output logic [7:0] IRR,
    output logic [7:0] ISR,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output pic_state_e STATE_DBG,
    output logic [2:0] LP_DBG
);

    pic_state_e r_state, w_state_nxt;
    logic                   r_int, w_int_nxt;
    logic [7:0]             r_irr, w_irr_nxt;
    logic [7:0]             r_isr, w_isr_nxt;
    logic [7:0]             r_dout, w_dout_nxt;
    logic                   r_doe, w_doe_nxt;
    logic [2:0]             r_lp, w_lp_nxt;
    logic [2:0]             r_level, w_level_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
`ifdef PIC_AEOI_EN
    logic                   r_aeoi, w_aeoi_nxt;
    logic                   r_spur, w_spur_nxt;
`endif

    logic       w_synced, w_fall, w_rise;
    logic       w_inta1, w_inta2, w_inta_end;
    logic       w_p_valid, w_h_valid;
    logic [2:0] w_p_level, w_h_level;
    logic [2:0] w_cmd, w_cmd_l;
    logic       w_unused_ocw2;

    assign w_synced      = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_hist & ~w_synced;
    assign w_rise        = ~r_hist & w_synced;
    assign w_cmd         = OCW2[7:5];
    assign w_cmd_l       = OCW2[2:0];
    assign w_unused_ocw2 = ^OCW2[4:3];

    pic_rot_priority u_pend (
        .i_vec   (r_irr & ~IMR),
        .i_lp    (r_lp),
        .o_valid (w_p_valid),
        .o_level (w_p_level)
    );

    pic_rot_priority u_serv (
        .i_vec   (r_isr),
        .i_lp    (r_lp),
        .o_valid (w_h_valid),
        .o_level (w_h_level)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], INTA_N};
            r_hist <= w_synced;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_nxt = ACK1;
            ACK1:    if (w_fall) w_state_nxt = ACK2;
            ACK2:    if (w_rise) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_inta1    = (r_state == IDLE) && w_fall;
    assign w_inta2    = (r_state == ACK1) && w_fall;
    assign w_inta_end = (r_state == ACK2) && w_rise;

    // EOI clears see the pre-update ISR; the INTA1 set is applied afterwards so it wins.
    always_comb begin
        w_irr_nxt   = r_irr | IR;
        w_isr_nxt   = r_isr;
        w_lp_nxt    = r_lp;
        w_level_nxt = r_level;
        w_dout_nxt  = r_dout;
        w_doe_nxt   = r_doe;
`ifdef PIC_AEOI_EN
        w_aeoi_nxt  = r_aeoi;
        w_spur_nxt  = r_spur;
`endif
        if (OCW2_WR) begin
            case (w_cmd)
                CMD_NS_EOI: begin
                    if (w_h_valid) w_isr_nxt[w_h_level] = 1'b0;
                end
                CMD_S_EOI: begin
                    w_isr_nxt[w_cmd_l] = 1'b0;
                end
                CMD_ROT_NS_EOI: begin
                    if (w_h_valid) begin
                        w_isr_nxt[w_h_level] = 1'b0;
                        w_lp_nxt             = w_h_level;
                    end
                end
                CMD_ROT_S_EOI: begin
                    w_isr_nxt[w_cmd_l] = 1'b0;
                    w_lp_nxt           = w_cmd_l;
                end
                CMD_SET_PRI: begin
                    w_lp_nxt = w_cmd_l;
                end
`ifdef PIC_AEOI_EN
                CMD_AEOI_SET: w_aeoi_nxt = 1'b1;
                CMD_AEOI_CLR: w_aeoi_nxt = 1'b0;
`endif
                default: ;
            endcase
        end
        if (w_inta1) begin
            if (w_p_valid) begin
                w_level_nxt            = w_p_level;
                w_isr_nxt[w_p_level]   = 1'b1;
                w_irr_nxt[w_p_level]   = 1'b0;
            end else begin
                w_level_nxt = SPURIOUS_LEVEL;
            end
`ifdef PIC_AEOI_EN
            w_spur_nxt = ~w_p_valid;
`endif
        end
        if (w_inta2) begin
            w_dout_nxt = {VECTOR_BASE, r_level};
            w_doe_nxt  = 1'b1;
        end
        if (w_inta_end) begin
            w_doe_nxt = 1'b0;
`ifdef PIC_AEOI_EN
            if (r_aeoi && !r_spur) begin
                w_isr_nxt[r_level] = 1'b0;
                w_lp_nxt           = r_level;
            end
`endif
        end
    end

    assign w_int_nxt = w_p_valid &&
                       (!w_h_valid || (prio_rank(w_p_level, r_lp) < prio_rank(w_h_level, r_lp)));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
            r_irr   <= 8'h00;
            r_isr   <= 8'h00;
            r_dout  <= 8'h00;
            r_doe   <= 1'b0;
            r_lp    <= LP_RESET;
            r_level <= SPURIOUS_LEVEL;
`ifdef PIC_AEOI_EN
            r_aeoi  <= 1'b0;
            r_spur  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_int   <= w_int_nxt;
            r_irr   <= w_irr_nxt;
            r_isr   <= w_isr_nxt;
            r_dout  <= w_dout_nxt;
            r_doe   <= w_doe_nxt;
            r_lp    <= w_lp_nxt;
            r_level <= w_level_nxt;
`ifdef PIC_AEOI_EN
            r_aeoi  <= w_aeoi_nxt;
            r_spur  <= w_spur_nxt;
`endif
        end
    end

    assign INT       = r_int;
    assign IRR       = r_irr;
    assign ISR       = r_isr;
    assign D_OUT     = r_dout;
    assign D_OE      = r_doe;
    assign STATE_DBG = r_state;
    assign LP_DBG    = r_lp;

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
- Clocked control block for the 8259A-style PIC.
- Latches interrupt requests and raises INT to the CPU.
- Runs the two-pulse INTA handshake, places the interrupt vector on the data bus, and maintains the ISR.
- Owns the rotating-priority pointer and decodes OCW2 EOI/rotate commands from the command-word decoder.

Parameters:
- LP_RESET, 3'd7: lowest-priority level after reset, which makes IR0 highest.
- SYNC_STAGES, 2: synchroniser depth on INTA_N (legal values 2 or 3).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, synchronous, active-low.
- IR  in  8  interrupt request lines, level-sensitive, already synchronous to CLK.
- IMR  in  8  interrupt mask, 1 = masked.
- VECTOR_BASE  in  5  vector bits T7..T3 from ICW2.
- OCW2  in  8  command word; R=[7], SL=[6], EOI=[5], L=[2:0].
- OCW2_WR  in  1  one-cycle strobe; OCW2 is valid this cycle.
- INTA_N  in  1  CPU acknowledge, asynchronous, active-low.
- INT  out  1  interrupt request to CPU.
- IRR  out  8  interrupt request register.
- ISR  out  8  in-service register.
- D_OUT  out  8  vector byte.
- D_OE  out  1  data bus drive enable.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: INT=0, IRR=0, ISR=0, D_OUT=0, D_OE=0, state=IDLE, LP=LP_RESET, synchroniser flops=1.
- IRR: each cycle, IRR[i] is set when IR[i]=1. It is cleared only by the INTA1 action for the selected level. A set and a clear on the same bit in the same cycle resolve to clear.
- Priority order: LP+1, LP+2, …, LP, all modulo 8 (3-bit wrap).
- Pending level P: the highest-priority i with IRR[i] & ~IMR[i].
- INT: registered. INT=1 when P exists and P ranks strictly above the highest-priority set ISR bit, or ISR==0. This gives 1-cycle latency from IRR/IMR/ISR change.
- INTA_N edges: INTA_N passes through SYNC_STAGES flops plus one history flop. A fall or rise is detected on the synced signal. Each action occurs in the cycle after detection.
- FSM IDLE -> ACK1, on falling edge 1:
  - If P exists: latch L=P, set ISR[L], clear IRR[L].
  - If no P (spurious): L=7, ISR and IRR unchanged.
- FSM ACK1 -> ACK2, on falling edge 2: D_OUT={VECTOR_BASE,L}, D_OE=1.
- FSM ACK2 -> IDLE, on rising edge: D_OE=0. D_OUT holds its value.
- Rising edge in IDLE or ACK1: ignored.
- Falling edge in ACK2: ignored. This cannot occur without an intervening rise.
- OCW2_WR commands, decoded on [7:5]; "highest ISR" uses the current priority order:
  - 001: non-specific EOI; clear the highest-priority set ISR bit. No-op if ISR==0.
  - 011: specific EOI; clear ISR[L].
  - 101: rotate on non-specific EOI; clear the highest ISR bit H and set LP=H. No-op if ISR==0.
  - 111: rotate on specific EOI; clear ISR[L] and set LP=L.
  - 110: set priority; LP=L.
  - 010: no-op.
  - 000/100: see Optional Feature.
- Simultaneous OCW2_WR and INTA1 action: the EOI clear is evaluated on the pre-update ISR, then the INTA1 set is applied. If both target the same bit, set wins. An LP update takes effect from the next cycle; the INTA1 selection uses the old LP.
- RST_N low mid-handshake: forces IDLE and D_OE=0 on the next edge; all registers take reset values.

Optional Feature:
- Macro PIC_AEOI_EN.
- Defined:
  - An aeoi_mode flag exists, reset 0. Command 100 sets it; command 000 clears it.
  - When aeoi_mode=1, the ACK2 -> IDLE transition also clears ISR[L] and sets LP=L (automatic rotation).
  - In the spurious case, nothing is cleared and LP is unchanged.
- Undefined: commands 000/100 are no-ops and ISR clears only through EOI commands.

Decomposition:
- Package pic_pkg:
  - state enum (IDLE, ACK1, ACK2);
  - OCW2 command localparams (CMD_NS_EOI=3'b001, CMD_S_EOI=3'b011, CMD_ROT_NS_EOI=3'b101, CMD_ROT_S_EOI=3'b111, CMD_SET_PRI=3'b110, CMD_AEOI_SET=3'b100, CMD_AEOI_CLR=3'b000);
  - SPURIOUS_LEVEL=3'd7.
- One sub-module, pic_rot_priority: purely combinational rotating find-first.
  - Inputs: 8-bit vector, 3-bit LP. Outputs: valid, 3-bit level.
  - Instantiated twice: once for pending IRR&~IMR, once for the highest ISR bit.

Test Plan:
- Reset, IR=8'h24, IMR=0, VECTOR_BASE=5'h11: INT=1. Two INTA pulses give D_OUT=8'h8A with D_OE high only during pulse 2, ISR=8'h04, IRR=8'h20.
- Continuing: while ISR[2]=1, INT stays 1 for IR5? No. INT=0 until OCW2=8'h20 (NS EOI). Then ISR=0 and INT=1; the next ack gives D_OUT=8'h8D.
- OCW2=8'hC4 (set priority, LP=4), IR=8'h21: ack selects IR5 (D_OUT low bits 101), not IR0.
- IR pulses high then drops to 0 before INTA: the IRR bit stays set. With IRR=0 and IMR=8'hFF, INTA pair gives D_OUT={VECTOR_BASE,3'd7} and ISR unchanged (spurious).
- RST_N=0 for one cycle between the two INTA pulses: state IDLE, D_OE stays 0 during the following INTA_N low, ISR=0.
- PIC_AEOI_EN defined, OCW2=8'h80, IR=8'h01: after the second INTA rising edge ISR=0 and LP=0, so the next priority order starts at IR1.
